// File: rtl/instr_encoder_pkg.sv
// Shared encoding definitions for the instruction encoder and the main decoder:
// opcode and FSM state enums, instruction field bit positions, and the packed
// field-level request payload.
package instr_encoder_pkg;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned COND_MSB  = 31;
  localparam int unsigned OP_LSB    = 26;
  localparam int unsigned FUNCT_LSB = 20;
  localparam int unsigned RN_LSB    = 16;
  localparam int unsigned RD_LSB    = 12;
  // Branch layout: fixed '1' at bit 25, link bit at 24, offset below.
  localparam int unsigned BR_ONE_BIT  = 25;
  localparam int unsigned BR_LINK_BIT = 24;

  typedef enum logic [1:0] {
    OP_DP  = 2'b00,
    OP_MEM = 2'b01,
    OP_BR  = 2'b10,
    OP_ILL = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic [3:0]  cond;
    op_e         op;
    logic [5:0]  funct;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [11:0] src2;
    logic [23:0] imm24;
  } instr_req_t;

endpackage

// File: rtl/instr_encoder_word_pack.sv
// instr_word_pack: combinational field-to-word packer.
//   req_i  : field-level instruction request
//   word_c : encoded 32-bit word (zero for the illegal opcode)
module instr_word_pack
  import instr_encoder_pkg::*;
(
  input  instr_req_t        req_i,
  output logic [WORD_W-1:0] word_c
);

  // DP/MEM carry funct/rn/rd/src2; branches carry link bit and 24-bit offset.
  always_comb begin
    word_c = '0;
    if (req_i.op != OP_ILL) begin
      word_c[COND_MSB -: 4] = req_i.cond;
      word_c[OP_LSB +: 2]   = req_i.op;
      if (req_i.op == OP_BR) begin
        word_c[BR_ONE_BIT]  = 1'b1;
        word_c[BR_LINK_BIT] = req_i.funct[4];
        word_c[23:0]        = req_i.imm24;
      end else begin
        word_c[FUNCT_LSB +: 6] = req_i.funct;
        word_c[RN_LSB +: 4]    = req_i.rn;
        word_c[RD_LSB +: 4]    = req_i.rd;
        word_c[11:0]           = req_i.src2;
      end
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: packs field-level instruction requests into 32-bit words and
// streams them into instruction memory during a load session.
//   start/busy/done            : session control and status
//   req_* / req_ready          : request channel (valid/ready)
//   mem_we/addr/wdata/ready    : memory write port, held stable under backpressure
//   word_count, err_*          : session results, held until the next start
//   checksum (ENCODER_CHECKSUM_EN only): XOR of every word written this session
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_last,
  input  logic [3:0]            req_cond,
  input  logic [1:0]            req_op,
  input  logic [5:0]            req_funct,
  input  logic [3:0]            req_rn,
  input  logic [3:0]            req_rd,
  input  logic [11:0]           req_src2,
  input  logic [23:0]           req_imm24,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WORD_W-1:0]     mem_wdata,
  input  logic                  mem_ready,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic                  err_illegal,
  output logic                  err_overflow
`ifdef ENCODER_CHECKSUM_EN
  ,
  output logic [WORD_W-1:0]     checksum
`endif
);

  localparam int unsigned CNT_W = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_BASE = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX  = '1;

  state_e                state_q, state_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [WORD_W-1:0]     mem_wdata_q, mem_wdata_d;
  logic [CNT_W-1:0]      word_count_q, word_count_d;
  logic                  err_illegal_q, err_illegal_d;
  logic                  err_overflow_q, err_overflow_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;
`ifdef ENCODER_CHECKSUM_EN
  logic [WORD_W-1:0]     checksum_q, checksum_d;
`endif

  instr_req_t        req_s;
  logic [WORD_W-1:0] word_c;
  logic              wr_done_c, at_max_c, accept_c;

  assign req_s = {req_cond, op_e'(req_op), req_funct, req_rn, req_rd, req_src2, req_imm24};

  instr_word_pack u_pack (
    .req_i  (req_s),
    .word_c (word_c)
  );

  assign wr_done_c = mem_we_q && mem_ready;
  assign at_max_c  = (mem_addr_q == ADDR_MAX);
  // A write completing at the top address ends the session, so no new
  // request may be taken in that cycle.
  assign req_ready = (state_q == LOAD) && (!mem_we_q || (mem_ready && !at_max_c));
  assign accept_c  = req_valid && req_ready;

  // Next-state, handshake and session bookkeeping.
  always_comb begin
    state_d        = state_q;
    mem_we_d       = mem_we_q;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    word_count_d   = word_count_q;
    err_illegal_d  = err_illegal_q;
    err_overflow_d = err_overflow_q;
`ifdef ENCODER_CHECKSUM_EN
    checksum_d     = checksum_q;
`endif

    if (wr_done_c) begin
      mem_we_d     = 1'b0;
      word_count_d = word_count_q + CNT_W'(1);
`ifdef ENCODER_CHECKSUM_EN
      checksum_d   = checksum_q ^ mem_wdata_q;
`endif
      if (at_max_c) begin
        err_overflow_d = 1'b1;
      end else begin
        mem_addr_d = mem_addr_q + ADDR_WIDTH'(1);
      end
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d        = LOAD;
          mem_addr_d     = ADDR_BASE;
          word_count_d   = '0;
          err_illegal_d  = 1'b0;
          err_overflow_d = 1'b0;
`ifdef ENCODER_CHECKSUM_EN
          checksum_d     = '0;
`endif
        end
      end
      LOAD: begin
        if (wr_done_c && at_max_c) begin
          state_d = DONE;
        end else if (accept_c) begin
          if (req_s.op == OP_ILL) begin
            err_illegal_d = 1'b1;
          end else begin
            mem_we_d    = 1'b1;
            mem_wdata_d = word_c;
          end
          if (req_last) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (!mem_we_q || wr_done_c) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    done_d = (state_d == DONE);
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset drops any pending write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= ADDR_BASE;
      mem_wdata_q    <= '0;
      word_count_q   <= '0;
      err_illegal_q  <= 1'b0;
      err_overflow_q <= 1'b0;
      done_q         <= 1'b0;
      busy_q         <= 1'b0;
`ifdef ENCODER_CHECKSUM_EN
      checksum_q     <= '0;
`endif
    end else begin
      state_q        <= state_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      word_count_q   <= word_count_d;
      err_illegal_q  <= err_illegal_d;
      err_overflow_q <= err_overflow_d;
      done_q         <= done_d;
      busy_q         <= busy_d;
`ifdef ENCODER_CHECKSUM_EN
      checksum_q     <= checksum_d;
`endif
    end
  end

  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign word_count   = word_count_q;
  assign err_illegal  = err_illegal_q;
  assign err_overflow = err_overflow_q;
  assign done         = done_q;
  assign busy         = busy_q;
`ifdef ENCODER_CHECKSUM_EN
  assign checksum     = checksum_q;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: directed sessions from the load-session
// scenarios plus randomized sessions, checked against a field-level model.
module tb_instr_encoder;

  localparam int unsigned AW   = 3;
  localparam int unsigned BASE = 0;
  localparam int unsigned CAP  = (1 << AW) - BASE;

  logic          clk;
  logic          reset;
  logic          start;
  logic          req_valid;
  logic          req_ready;
  logic          req_last;
  logic [3:0]    req_cond;
  logic [1:0]    req_op;
  logic [5:0]    req_funct;
  logic [3:0]    req_rn;
  logic [3:0]    req_rd;
  logic [11:0]   req_src2;
  logic [23:0]   req_imm24;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_ready;
  logic          busy;
  logic          done;
  logic [AW:0]   word_count;
  logic          err_illegal;
  logic          err_overflow;
`ifdef ENCODER_CHECKSUM_EN
  logic [31:0]   checksum;
`endif

  instr_encoder #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .start(start),
    .req_valid(req_valid), .req_ready(req_ready), .req_last(req_last),
    .req_cond(req_cond), .req_op(req_op), .req_funct(req_funct),
    .req_rn(req_rn), .req_rd(req_rd), .req_src2(req_src2), .req_imm24(req_imm24),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .busy(busy), .done(done), .word_count(word_count),
    .err_illegal(err_illegal), .err_overflow(err_overflow)
`ifdef ENCODER_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  cond;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [11:0] src2;
    logic [23:0] imm24;
  } req_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  typedef struct {
    int          words;
    bit          ill;
    bit          ovf;
    logic [31:0] csum;
  } sess_t;

  wr_t   exp_wr[$];
  sess_t exp_sess[$];

  int n_checks = 0;
  int n_fail   = 0;
  int ready_pct = 100;

  int          sess_words;
  bit          sess_ill;
  bit          sess_open;
  logic [31:0] sess_csum;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Reference encoding built from field positions with plain arithmetic.
  function automatic logic [31:0] enc(input req_t r);
    logic [31:0] w;
    w = (32'(r.cond) << 28) | (32'(r.op) << 26);
    if (r.op == 2'd2)
      w = w | (32'd1 << 25) | (32'(r.funct[4]) << 24) | 32'(r.imm24);
    else
      w = w | (32'(r.funct) << 20) | (32'(r.rn) << 16) | (32'(r.rd) << 12) | 32'(r.src2);
    return w;
  endfunction

  function automatic req_t mk(input logic [3:0] c, input logic [1:0] op, input logic [5:0] f,
                              input logic [3:0] rn, input logic [3:0] rd,
                              input logic [11:0] s2, input logic [23:0] i24);
    req_t r;
    r.cond = c; r.op = op; r.funct = f; r.rn = rn; r.rd = rd; r.src2 = s2; r.imm24 = i24;
    return r;
  endfunction

  function automatic req_t rand_req(input int ill_pct);
    req_t r;
    r.cond  = 4'($urandom);
    r.op    = ($urandom_range(99) < ill_pct) ? 2'd3 : 2'($urandom_range(2));
    r.funct = 6'($urandom);
    r.rn    = 4'($urandom);
    r.rd    = 4'($urandom);
    r.src2  = 12'($urandom);
    r.imm24 = 24'($urandom);
    return r;
  endfunction

  task automatic tick();
    @(negedge clk);
    mem_ready = ($urandom_range(99) < ready_pct);
  endtask

  task automatic drive(input req_t r, input bit last);
    req_cond = r.cond; req_op = r.op; req_funct = r.funct; req_rn = r.rn;
    req_rd = r.rd; req_src2 = r.src2; req_imm24 = r.imm24; req_last = last;
    req_valid = 1'b1;
  endtask

  // Model: legal words land at consecutive addresses; session closes on last or when full.
  task automatic model_accept(input req_t r, input bit last);
    wr_t w;
    sess_t s;
    if (r.op == 2'd3) begin
      sess_ill = 1'b1;
    end else begin
      w.addr = AW'(BASE + sess_words);
      w.data = enc(r);
      exp_wr.push_back(w);
      sess_words++;
      sess_csum ^= w.data;
    end
    if (last || sess_words == CAP) begin
      s.words = sess_words; s.ill = sess_ill; s.ovf = (sess_words == CAP); s.csum = sess_csum;
      exp_sess.push_back(s);
      sess_open = 1'b0;
    end
  endtask

  task automatic start_session();
    sess_words = 0; sess_ill = 1'b0; sess_csum = '0; sess_open = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input req_t r, input bit last, output bit acc, output int waits);
    acc = 1'b0;
    waits = 0;
    drive(r, last);
    while (!acc && waits < 200) begin
      #1;
      if (req_ready) begin
        acc = 1'b1;
        model_accept(r, last);
      end else begin
        waits++;
      end
      tick();
    end
    req_valid = 1'b0;
    req_last  = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_sess.size() != 0 || busy) && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) fail_now("session_end_timeout");
  endtask

  task automatic offer_rejected(input req_t r);
    int hits = 0;
    drive(r, 1'b0);
    repeat (20) begin
      #1;
      if (req_ready && req_valid) hits++;
      tick();
    end
    req_valid = 1'b0;
    chk("no_accept_after_full", hits, 0);
  endtask

  task automatic run_session(input int n, input int ill_pct, input int gap_max);
    bit acc;
    int w;
    bit last_sent = 1'b0;
    start_session();
    for (int i = 0; i < n && sess_open; i++) begin
      repeat ($urandom_range(gap_max)) tick();
      send(rand_req(ill_pct), (i == n - 1), acc, w);
      if (!acc) fail_now("request_not_accepted");
      if (acc && i == n - 1) last_sent = 1'b1;
    end
    if (sess_words == CAP && !last_sent) offer_rejected(rand_req(0));
    wait_idle();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_word_count"}, word_count, 0);
    chk({tag, "_errs"}, {err_illegal, err_overflow}, 0);
    chk({tag, "_mem_addr"}, mem_addr, BASE);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
  endtask

  // Monitor: samples 1 time unit before each rising edge.
  initial begin : monitor
    bit          stall_prev = 1'b0;
    bit          done_prev  = 1'b0;
    logic [AW-1:0] sa;
    logic [31:0] sd;
    wr_t   w;
    sess_t s;
    forever begin
      @(negedge clk);
      #4;
      if (!reset) begin
        stall_prev = 1'b0;
        done_prev  = 1'b0;
      end else begin
        if (stall_prev) begin
          chk("stall_we_held", mem_we, 1);
          chk("stall_addr_stable", mem_addr, sa);
          chk("stall_data_stable", mem_wdata, sd);
        end
        stall_prev = mem_we && !mem_ready;
        sa = mem_addr;
        sd = mem_wdata;
        if (mem_we && mem_ready) begin
          if (exp_wr.size() == 0) begin
            fail_now("unexpected_write");
          end else begin
            w = exp_wr.pop_front();
            chk("write_addr", mem_addr, w.addr);
            chk("write_data", mem_wdata, w.data);
          end
        end
        if (done_prev) chk("done_one_cycle", done, 0);
        done_prev = done;
        if (done) begin
          if (exp_sess.size() == 0) begin
            fail_now("unexpected_done");
          end else begin
            s = exp_sess.pop_front();
            chk("writes_outstanding_at_done", exp_wr.size(), 0);
            chk("word_count", word_count, s.words);
            chk("err_illegal", err_illegal, s.ill);
            chk("err_overflow", err_overflow, s.ovf);
`ifdef ENCODER_CHECKSUM_EN
            chk("checksum", checksum, s.csum);
`endif
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bit acc;
    int w;
    reset = 1'b0; start = 1'b0; mem_ready = 1'b0;
    req_valid = 1'b0; req_last = 1'b0; req_cond = '0; req_op = '0; req_funct = '0;
    req_rn = '0; req_rd = '0; req_src2 = '0; req_imm24 = '0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    tick();
    reset = 1'b1;
    tick();
    tick();

    // ADD r2, r1, #3 as a single-word session.
    ready_pct = 100;
    start_session();
    send(mk(4'hE, 2'd0, 6'b001000, 4'd1, 4'd2, 12'h003, 24'h0), 1'b1, acc, w);
    chk("add_accepted", acc, 1);
    wait_idle();

    // LDR then B, back-to-back.
    start_session();
    send(mk(4'hE, 2'd1, 6'b011001, 4'd1, 4'd0, 12'h004, 24'h0), 1'b0, acc, w);
    send(mk(4'hE, 2'd2, 6'b100000, 4'd0, 4'd0, 12'h0, 24'h000002), 1'b1, acc, w);
    chk("b2b_no_wait", w, 0);
    wait_idle();

    // Write stalled for three cycles: request side must be blocked.
    ready_pct = 0;
    start_session();
    send(mk(4'hE, 2'd0, 6'b001000, 4'd3, 4'd4, 12'h0FF, 24'h0), 1'b0, acc, w);
    drive(mk(4'hE, 2'd2, 6'b010000, 4'd0, 4'd0, 12'h0, 24'h0ABCDE), 1'b1);
    repeat (3) begin
      #1;
      chk("stall_req_ready", req_ready, 0);
      tick();
    end
    mem_ready = 1'b1;
    ready_pct = 100;
    send(mk(4'hE, 2'd2, 6'b010000, 4'd0, 4'd0, 12'h0, 24'h0ABCDE), 1'b1, acc, w);
    chk("stall_then_accept", w, 0);
    wait_idle();

    // Illegal opcode between two valid requests.
    start_session();
    send(mk(4'h0, 2'd0, 6'b000100, 4'd5, 4'd6, 12'h123, 24'h0), 1'b0, acc, w);
    send(mk(4'hE, 2'd3, 6'b111111, 4'd7, 4'd7, 12'hFFF, 24'hFFFFFF), 1'b0, acc, w);
    send(mk(4'h1, 2'd1, 6'b011000, 4'd2, 4'd3, 12'h008, 24'h0), 1'b1, acc, w);
    wait_idle();

    // Fill the whole address space without a last marker.
    run_session(CAP + 1, 0, 0);
    ready_pct = 60;
    run_session(CAP + 3, 20, 1);

    // Reset in the middle of a stalled write, then a normal session.
    ready_pct = 0;
    start_session();
    send(mk(4'hE, 2'd0, 6'b001000, 4'd1, 4'd2, 12'h003, 24'h0), 1'b0, acc, w);
    tick();
    tick();
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("midreset");
    exp_wr.delete();
    exp_sess.delete();
    sess_open = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    ready_pct = 100;
    start_session();
    send(mk(4'hE, 2'd1, 6'b011001, 4'd1, 4'd0, 12'h004, 24'h0), 1'b1, acc, w);
    chk("post_reset_accepted", acc, 1);
    wait_idle();

    // Randomized sessions under random backpressure.
    for (int k = 0; k < 25; k++) begin
      ready_pct = $urandom_range(30, 100);
      run_session($urandom_range(1, 11), 15, 2);
    end

    repeat (5) tick();
    chk("queues_drained", exp_wr.size() + exp_sess.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
Inverse of the main decoder. Packs field-level instruction requests into 32-bit ARM words using the same op/funct layout the decoder consumes, and streams them into instruction memory through a write port with backpressure. Used by the boot/self-test loader to build programs in instruction memory before the core is released.

Parameters:
ADDR_WIDTH, 8, word-address width of the instruction-memory write port.
BASE_ADDR, 0, first word address written after start.

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a load session (ignored unless IDLE)
req_valid  in  1  request present
req_ready  out  1  request accepted when valid&&ready
req_last  in  1  request is the final word of the session
req_cond  in  4  condition field
req_op  in  2  00 DP, 01 MEM, 10 B, 11 illegal
req_funct  in  6  funct field, same bit meaning the decoder uses
req_rn  in  4  Rn
req_rd  in  4  Rd
req_src2  in  12  imm12 or Rm/shift field (DP/MEM)
req_imm24  in  24  branch offset (B only)
mem_we  out  1  write strobe, held until mem_ready
mem_addr  out  ADDR_WIDTH  word address
mem_wdata  out  32  encoded word
mem_ready  in  1  memory accepts current write
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at end of session
word_count  out  ADDR_WIDTH+1  words written this session
err_illegal  out  1  sticky; op=11 seen this session
err_overflow  out  1  sticky; address space exhausted

Behaviour:
- Reset (async, reset=0): state IDLE; all outputs 0; mem_addr=BASE_ADDR.
- FSM IDLE -> LOAD on start; clears word_count and both error flags, mem_addr=BASE_ADDR.
- LOAD: req_ready = !mem_we || mem_ready. Accepted request registers encoded word; mem_we asserts the next cycle (latency 1). Write completes on mem_we&&mem_ready; mem_addr increments and word_count increments on completion.
- Encoding: op 00/01 -> {cond, op, funct, rn, rd, src2}; op 10 -> {cond, 2'b10, 1'b1, funct[4], imm24}; funct[5] and src2/rn/rd ignored for B.
- op=11: request accepted, nothing written, address/count unchanged, err_illegal set.
- Accepted req_last -> DRAIN; DRAIN waits for the pending write (if any) to complete, then -> DONE.
- Overflow: write completing at address 2^ADDR_WIDTH-1 sets err_overflow, no wrap, -> DONE (remaining requests not accepted).
- DONE: done=1 for exactly one cycle -> IDLE. Flags and word_count hold until next start.
- start in LOAD/DRAIN/DONE ignored. Accept and write-complete in the same cycle are legal (back-to-back throughput 1 word/cycle).
- mem_addr/mem_wdata must not change while mem_we=1 and mem_ready=0.
- Reset mid-session aborts immediately; a pending write is dropped.

Optional Feature:
ENCODER_CHECKSUM_EN: adds output checksum[31:0], XOR of every word written this session, cleared on start, final at done. Without it the port is absent and no checksum logic exists.

Decomposition:
- Package instr_encoder_pkg: op enum (OP_DP=2'b00, OP_MEM=2'b01, OP_BR=2'b10), state enum (IDLE, LOAD, DRAIN, DONE), field bit-position constants (COND_MSB=31, OP_LSB=26, FUNCT_LSB=20, RN_LSB=16, RD_LSB=12). The decoder shares these.
- Sub-module instr_word_pack: pure combinational field-to-word packer; FSM, handshake and counters stay in instr_encoder.

Test Plan:
- start; ADD: cond=E op=00 funct=001000 rn=1 rd=2 src2=003, last=1, mem_ready=1 -> one write addr 0 data 0xE0812003; done 2 cycles later; word_count=1.
- LDR imm: op=01 funct=011001 rn=1 rd=0 src2=004, then B: op=10 funct=100000 imm24=000002 last -> writes 0xE5910004 @0, 0xEA000002 @1, back-to-back.
- Stall: mem_ready=0 for 3 cycles during write -> mem_we/addr/data stable, req_ready=0; completes on 4th cycle, then addr increments.
- Illegal: op=11 between two valid requests -> err_illegal=1, only 2 writes at addrs 0,1, word_count=2.
- Overflow: ADDR_WIDTH=2, 5 requests no last -> writes addrs 0..3, err_overflow=1, done, 5th request never accepted.
- Reset low mid-LOAD with pending stalled write -> all outputs 0 same cycle, state IDLE, next start behaves normally.
